// File: rtl/ifft_cp_framer_if.sv
// Streaming bus for the IFFT cyclic-prefix framer: sample input stream from the
// IFFT and framed time-domain output stream.
interface ifft_cp_framer_if #(
    parameter int DATA_W = 28,
    parameter int LOG2N  = 7
);
    logic [DATA_W-1:0] S_DATA_RE_IN;
    logic [DATA_W-1:0] S_DATA_IM_IN;
    logic [LOG2N-1:0]  S_DATA_INDEX_IN;
    logic              S_DATA_VALID;
    logic              S_DATA_LAST;
    logic              S_DATA_READY;
    logic [DATA_W-1:0] M_DATA_RE_OUT;
    logic [DATA_W-1:0] M_DATA_IM_OUT;
    logic              M_DATA_VALID;
    logic              M_DATA_READY;
    logic              M_DATA_FIRST;
    logic              M_DATA_LAST;
    logic              EVENT_LAST_MISMATCH;

    modport master (
        output S_DATA_RE_IN, S_DATA_IM_IN, S_DATA_INDEX_IN, S_DATA_VALID, S_DATA_LAST,
        output M_DATA_READY,
        input  S_DATA_READY, M_DATA_RE_OUT, M_DATA_IM_OUT, M_DATA_VALID,
        input  M_DATA_FIRST, M_DATA_LAST, EVENT_LAST_MISMATCH
    );

    modport slave (
        input  S_DATA_RE_IN, S_DATA_IM_IN, S_DATA_INDEX_IN, S_DATA_VALID, S_DATA_LAST,
        input  M_DATA_READY,
        output S_DATA_READY, M_DATA_RE_OUT, M_DATA_IM_OUT, M_DATA_VALID,
        output M_DATA_FIRST, M_DATA_LAST, EVENT_LAST_MISMATCH
    );
endinterface

// File: rtl/ifft_cp_framer.sv
// Ping-pong symbol buffer that reorders IFFT output by time index and emits
// each symbol as cyclic prefix (last CP_LEN samples) followed by the full body.
module ifft_cp_framer #(
    parameter int DATA_W    = 28,
    parameter int LOG2N     = 7,
    parameter int CP_LEN    = 32,
    parameter int REAL_ONLY = 0
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    ifft_cp_framer_if.slave  bus
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX   = '1;
    localparam logic [LOG2N-1:0] START_ADDR = LOG2N'(N - CP_LEN);

    typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_e;
    localparam rd_state_e START_ST = (CP_LEN > 0) ? CP : BODY;

    logic [2*DATA_W-1:0] mem [2*N];
    logic [2*DATA_W-1:0] rd_data_q;

    logic                  wr_bank_q, wr_bank_d;
    logic [1:0][LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]            full_q, full_d;
    logic                  evt_q, evt_d;
    logic                  s_ready, accept, commit;

    rd_state_e         state_q, cur_st;
    logic              rd_bank_q;
    logic [LOG2N-1:0]  rd_addr_q, cur_addr;
    logic              s1_vld_q, s1_first_q, s1_last_q;
    logic              m_vld_q, m_first_q, m_last_q;
    logic [DATA_W-1:0] m_re_q, m_im_q;
    logic              adv, cur_vld, issue, free, other_full;

    always_comb begin
        s_ready = !RST && !full_q[wr_bank_q];
        accept  = bus.S_DATA_VALID && s_ready;
        commit  = accept && (wr_cnt_q[wr_bank_q] == LAST_IDX);
    end

    // Commit is purely count-based; a misplaced LAST only raises the event.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        full_d    = full_q;
        evt_d     = accept && (bus.S_DATA_LAST != (wr_cnt_q[wr_bank_q] == LAST_IDX));
        if (accept)
            wr_cnt_d[wr_bank_q] = commit ? '0 : wr_cnt_q[wr_bank_q] + LOG2N'(1);
        if (commit)
            wr_bank_d = ~wr_bank_q;
        for (int b = 0; b < 2; b++)
            full_d[b] = (full_q[b] && !(free && rd_bank_q == 1'(b)))
                      || (commit && wr_bank_q == 1'(b));
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
            evt_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
            evt_q     <= evt_d;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (accept)
            mem[{wr_bank_q, bus.S_DATA_INDEX_IN}] <= {bus.S_DATA_RE_IN, bus.S_DATA_IM_IN};
    end

    // IDLE issues the first address itself so the first beat lands two edges after commit.
    always_comb begin
        adv = !m_vld_q || bus.M_DATA_READY;
        if (state_q == IDLE) begin
            cur_vld  = full_q[rd_bank_q];
            cur_st   = START_ST;
            cur_addr = START_ADDR;
        end else begin
            cur_vld  = 1'b1;
            cur_st   = state_q;
            cur_addr = rd_addr_q;
        end
        issue      = adv && cur_vld;
        free       = issue && (cur_st == BODY) && (cur_addr == LAST_IDX);
        other_full = full_q[~rd_bank_q] || (commit && wr_bank_q != rd_bank_q);
    end

    // RAM read stage freezes with the output register so stalls lose nothing.
    always_ff @(posedge SYS_CLK) begin
        if (adv)
            rd_data_q <= mem[{rd_bank_q, cur_addr}];
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            m_vld_q    <= 1'b0;
            m_first_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_re_q     <= '0;
            m_im_q     <= '0;
        end else if (adv) begin
            m_vld_q    <= s1_vld_q;
            m_first_q  <= s1_first_q;
            m_last_q   <= s1_last_q;
            m_re_q     <= rd_data_q[2*DATA_W-1:DATA_W];
            m_im_q     <= (REAL_ONLY != 0) ? '0 : rd_data_q[DATA_W-1:0];
            s1_vld_q   <= issue;
            s1_first_q <= issue && (cur_st == START_ST) && (cur_addr == START_ADDR);
            s1_last_q  <= free;
            if (issue) begin
                if (free) begin
                    rd_bank_q <= ~rd_bank_q;
                    state_q   <= other_full ? START_ST : IDLE;
                    rd_addr_q <= START_ADDR;
                end else if (cur_st == CP && cur_addr == LAST_IDX) begin
                    state_q   <= BODY;
                    rd_addr_q <= '0;
                end else begin
                    state_q   <= cur_st;
                    rd_addr_q <= cur_addr + LOG2N'(1);
                end
            end
        end
    end

    assign bus.S_DATA_READY        = s_ready;
    assign bus.EVENT_LAST_MISMATCH = evt_q;
    assign bus.M_DATA_VALID        = m_vld_q;
    assign bus.M_DATA_FIRST        = m_first_q;
    assign bus.M_DATA_LAST         = m_last_q;
    assign bus.M_DATA_RE_OUT       = m_re_q;
    assign bus.M_DATA_IM_OUT       = m_im_q;
endmodule

// File: tb/tb_ifft_cp_framer.sv
// Bench for ifft_cp_framer: default build plus a CP_LEN=0 / REAL_ONLY=1 build
// fed the same input stream, checked against a queue-based framing model.
module tb_ifft_cp_framer;
    localparam int DW = 28, LOG2N = 7, N = 128, CP = 32, TOT = CP + N;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          first;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [DW-1:0]    s_re, s_im;
    logic [LOG2N-1:0] s_idx;
    logic             s_vld, s_last, m_rdy;
    bit               rand_rdy;
    int               cyc, errors, checks, evt_cnt, stall_err;
    beat_t            exp_q[$], obs_q[$], exp0_q[$], obs0_q[$];
    int               obs_cyc[$];
    logic [DW-1:0]    sym_re[N], sym_im[N];
    beat_t            col_b, prev_b, col0_b;
    logic             prev_stall;

    ifft_cp_framer_if #(.DATA_W(DW), .LOG2N(LOG2N)) bus ();
    ifft_cp_framer_if #(.DATA_W(DW), .LOG2N(LOG2N)) bus0 ();

    assign bus.S_DATA_RE_IN     = s_re;
    assign bus.S_DATA_IM_IN     = s_im;
    assign bus.S_DATA_INDEX_IN  = s_idx;
    assign bus.S_DATA_VALID     = s_vld;
    assign bus.S_DATA_LAST      = s_last;
    assign bus.M_DATA_READY     = m_rdy;
    assign bus0.S_DATA_RE_IN    = s_re;
    assign bus0.S_DATA_IM_IN    = s_im;
    assign bus0.S_DATA_INDEX_IN = s_idx;
    assign bus0.S_DATA_VALID    = s_vld;
    assign bus0.S_DATA_LAST     = s_last;
    assign bus0.M_DATA_READY    = m_rdy;

    ifft_cp_framer #(.DATA_W(DW), .LOG2N(LOG2N), .CP_LEN(CP), .REAL_ONLY(0)) dut (
        .SYS_CLK(clk), .RST(rst), .bus(bus));
    ifft_cp_framer #(.DATA_W(DW), .LOG2N(LOG2N), .CP_LEN(0), .REAL_ONLY(1)) dut0 (
        .SYS_CLK(clk), .RST(rst), .bus(bus0));

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Passive collector: records handshaken beats and watches stalled outputs.
    always @(negedge clk) begin
        col_b.re    = bus.M_DATA_RE_OUT;
        col_b.im    = bus.M_DATA_IM_OUT;
        col_b.first = bus.M_DATA_FIRST;
        col_b.last  = bus.M_DATA_LAST;
        if (!rst && prev_stall && (!bus.M_DATA_VALID || col_b !== prev_b)) stall_err++;
        prev_stall = !rst && bus.M_DATA_VALID && !m_rdy;
        prev_b     = col_b;
        if (!rst && bus.M_DATA_VALID && m_rdy) begin
            obs_q.push_back(col_b);
            obs_cyc.push_back(cyc);
        end
        if (!rst && bus.EVENT_LAST_MISMATCH) evt_cnt++;
        col0_b.re    = bus0.M_DATA_RE_OUT;
        col0_b.im    = bus0.M_DATA_IM_OUT;
        col0_b.first = bus0.M_DATA_FIRST;
        col0_b.last  = bus0.M_DATA_LAST;
        if (!rst && bus0.M_DATA_VALID && m_rdy) obs0_q.push_back(col0_b);
    end

    function automatic logic [LOG2N-1:0] brev(input int x);
        logic [LOG2N-1:0] v, r;
        v = LOG2N'(x);
        for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
        return r;
    endfunction

    function automatic void gen_symbol(input int mode);
        for (int k = 0; k < N; k++) begin
            sym_re[k] = (mode == 0) ? DW'(k) : DW'($urandom);
            sym_im[k] = (mode == 0) ? (DW'(k) ^ DW'('h5A5A5A5)) : DW'($urandom);
        end
    endfunction

    // Framing model: prefix is the tail of the symbol, then the whole symbol in time order.
    function automatic void push_exp();
        beat_t b;
        int idx;
        for (int j = 0; j < TOT; j++) begin
            idx     = (j < CP) ? (N - CP + j) : (j - CP);
            b.re    = sym_re[idx];
            b.im    = sym_im[idx];
            b.first = (j == 0);
            b.last  = (j == TOT - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic send_symbol(input int order, input int last_pos);
        logic [LOG2N-1:0] idx;
        bit acc;
        for (int i = 0; i < N; i++) begin
            idx    = (order == 1) ? brev(i) : LOG2N'(i);
            s_idx  = idx;
            s_re   = sym_re[idx];
            s_im   = sym_im[idx];
            s_last = (i == last_pos);
            s_vld  = 1'b1;
            acc    = 0;
            for (int t = 0; t < 3000 && !acc; t++) begin
                @(negedge clk);
                if (bus.S_DATA_READY) begin
                    @(posedge clk); #1;
                    acc = 1;
                end
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL send_timeout beat %0d not accepted within budget", i);
                s_vld = 1'b0; s_last = 1'b0;
                return;
            end
        end
        s_vld = 1'b0; s_last = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; s_vld = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete(); exp0_q.delete(); obs0_q.delete();
        evt_cnt = 0; stall_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_vld = 1'b0; s_last = 1'b0; m_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.S_DATA_READY !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", bus.S_DATA_READY); end
        checks++; if ({bus.M_DATA_VALID, bus.M_DATA_FIRST, bus.M_DATA_LAST, bus.EVENT_LAST_MISMATCH} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b%b%b%b exp 0000", bus.M_DATA_VALID, bus.M_DATA_FIRST, bus.M_DATA_LAST, bus.EVENT_LAST_MISMATCH); end
        checks++; if ({bus.M_DATA_RE_OUT, bus.M_DATA_IM_OUT} !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0/0", bus.M_DATA_RE_OUT, bus.M_DATA_IM_OUT); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.S_DATA_READY !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %b exp 1", bus.S_DATA_READY); end
        checks++; if (bus0.S_DATA_READY !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready0 got %b exp 1", bus0.S_DATA_READY); end
    endtask

    task automatic test_single_symbol(input int order, input string nm);
        do_reset();
        m_rdy = 1'b1;
        gen_symbol(0);
        push_exp();
        send_symbol(order, N - 1);
        checks++; if (bus.M_DATA_VALID !== 1'b0) begin errors++; $display("FAIL %s lat_edge0 valid got %b exp 0", nm, bus.M_DATA_VALID); end
        @(posedge clk); #1;
        checks++; if (bus.M_DATA_VALID !== 1'b0) begin errors++; $display("FAIL %s lat_edge1 valid got %b exp 0", nm, bus.M_DATA_VALID); end
        @(posedge clk); #1;
        checks++; if ({bus.M_DATA_VALID, bus.M_DATA_FIRST} !== 2'b11) begin
            errors++; $display("FAIL %s lat_edge2 valid/first got %b%b exp 11", nm, bus.M_DATA_VALID, bus.M_DATA_FIRST); end
        for (int t = 0; t < 2000 && obs_q.size() < TOT; t++) @(posedge clk);
        repeat (10) @(posedge clk);
        checks++; if (obs_q.size() != TOT) begin errors++; $display("FAIL %s beat_count got %0d exp %0d", nm, obs_q.size(), TOT); end
        for (int i = 0; i < TOT && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s beat %0d got %h exp %h", nm, i, obs_q[i], exp_q[i]); end
        end
        checks++; if (evt_cnt != 0) begin errors++; $display("FAIL %s mismatch_events got %0d exp 0", nm, evt_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_rdy = 1'b0;
        for (int s = 0; s < 2; s++) begin
            gen_symbol(1);
            push_exp();
            send_symbol(s, N - 1);
        end
        checks++; if (bus.S_DATA_READY !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got %b exp 0", bus.S_DATA_READY); end
        @(negedge clk);
        checks++; if ({bus.M_DATA_VALID, bus.M_DATA_FIRST, bus.S_DATA_READY} !== 3'b110) begin
            errors++; $display("FAIL b2b_stalled got v%b f%b r%b exp v1 f1 r0", bus.M_DATA_VALID, bus.M_DATA_FIRST, bus.S_DATA_READY); end
        @(posedge clk); #1;
        m_rdy = 1'b1;
        gen_symbol(1);
        push_exp();
        send_symbol(0, N - 1);
        for (int t = 0; t < 3000 && obs_q.size() < 3*TOT; t++) @(posedge clk);
        repeat (10) @(posedge clk);
        checks++; if (obs_q.size() != 3*TOT) begin errors++; $display("FAIL b2b_beat_count got %0d exp %0d", obs_q.size(), 3*TOT); end
        for (int i = 0; i < 3*TOT && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b beat %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 3*TOT) begin
            checks++;
            if (obs_cyc[3*TOT-1] - obs_cyc[0] != 3*TOT - 1) begin
                errors++; $display("FAIL b2b_contiguous span got %0d exp %0d", obs_cyc[3*TOT-1] - obs_cyc[0], 3*TOT - 1); end
        end
    endtask

    task automatic test_random_stall();
        do_reset();
        rand_rdy = 1;
        for (int s = 0; s < 3; s++) begin
            gen_symbol(1);
            push_exp();
            send_symbol(int'($urandom_range(0, 1)), N - 1);
        end
        for (int t = 0; t < 20000 && obs_q.size() < 3*TOT; t++) @(posedge clk);
        rand_rdy = 0;
        @(posedge clk); #2;
        m_rdy = 1'b1;
        repeat (10) @(posedge clk);
        checks++; if (obs_q.size() != 3*TOT) begin errors++; $display("FAIL rand_beat_count got %0d exp %0d", obs_q.size(), 3*TOT); end
        for (int i = 0; i < 3*TOT && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand beat %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL rand_stall_stability got %0d changes exp 0", stall_err); end
    endtask

    task automatic test_last_mismatch();
        do_reset();
        m_rdy = 1'b1;
        gen_symbol(1);
        push_exp();
        send_symbol(0, 100);
        for (int t = 0; t < 2000 && obs_q.size() < TOT; t++) @(posedge clk);
        repeat (10) @(posedge clk);
        checks++; if (evt_cnt != 2) begin errors++; $display("FAIL last_mismatch_events got %0d exp 2", evt_cnt); end
        checks++; if (obs_q.size() != TOT) begin errors++; $display("FAIL last_mismatch_count got %0d exp %0d", obs_q.size(), TOT); end
        for (int i = 0; i < TOT && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL last_mismatch beat %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_rdy = 1'b0;
        gen_symbol(1); send_symbol(0, N - 1);
        gen_symbol(1); send_symbol(0, N - 1);
        @(posedge clk); #1;
        m_rdy = 1'b1;
        for (int t = 0; t < 2000 && obs_q.size() < 50; t++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({bus.M_DATA_VALID, bus.M_DATA_FIRST, bus.M_DATA_LAST, bus.EVENT_LAST_MISMATCH, bus.S_DATA_READY} !== 5'b0) begin
            errors++; $display("FAIL midrst_flags got v%b f%b l%b e%b r%b exp all 0", bus.M_DATA_VALID, bus.M_DATA_FIRST,
                bus.M_DATA_LAST, bus.EVENT_LAST_MISMATCH, bus.S_DATA_READY); end
        checks++; if ({bus.M_DATA_RE_OUT, bus.M_DATA_IM_OUT} !== '0) begin
            errors++; $display("FAIL midrst_data got %h/%h exp 0/0", bus.M_DATA_RE_OUT, bus.M_DATA_IM_OUT); end
        @(posedge clk); #1;
        rst = 1'b0;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete(); evt_cnt = 0;
        repeat (400) @(posedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_stale_beats got %0d exp 0", obs_q.size()); end
        #1;
        gen_symbol(1);
        push_exp();
        send_symbol(1, N - 1);
        for (int t = 0; t < 2000 && obs_q.size() < TOT; t++) @(posedge clk);
        repeat (10) @(posedge clk);
        checks++; if (obs_q.size() != TOT) begin errors++; $display("FAIL midrst_new_count got %0d exp %0d", obs_q.size(), TOT); end
        for (int i = 0; i < TOT && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst beat %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cp0_real();
        beat_t b;
        do_reset();
        m_rdy = 1'b1;
        gen_symbol(1);
        for (int k = 0; k < N; k++) begin
            b.re = sym_re[k]; b.im = '0; b.first = (k == 0); b.last = (k == N - 1);
            exp0_q.push_back(b);
        end
        send_symbol(1, N - 1);
        for (int t = 0; t < 2000 && obs0_q.size() < N; t++) @(posedge clk);
        repeat (10) @(posedge clk);
        checks++; if (obs0_q.size() != N) begin errors++; $display("FAIL cp0_beat_count got %0d exp %0d", obs0_q.size(), N); end
        for (int i = 0; i < N && i < obs0_q.size(); i++) begin
            checks++;
            if (obs0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL cp0 beat %0d got %h exp %h", i, obs0_q[i], exp0_q[i]); end
        end
    endtask

    initial begin
        errors = 0; checks = 0; evt_cnt = 0; stall_err = 0; rand_rdy = 0; prev_stall = 1'b0;
        s_re = '0; s_im = '0; s_idx = '0;
        test_reset();
        test_single_symbol(0, "inorder");
        test_single_symbol(1, "bitrev");
        test_back_to_back();
        test_random_stall();
        test_last_mismatch();
        test_reset_mid();
        test_cp0_real();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifft_cp_framer.md
IFFT_CP_FRAMER -- requirements
Module: ifft_cp_framer

Interface
REQ-001 Parameter DATA_W, default 28, width of each real/imag sample.
REQ-002 Parameter LOG2N, default 7, log2 of IFFT size N (N=128 default).
REQ-003 Parameter CP_LEN, default 32, cyclic-prefix length; legal range 0..N-1.
REQ-004 Parameter REAL_ONLY, default 0; 1 forces M_DATA_IM_OUT to zero (DMT real output).
REQ-005 SYS_CLK  in  1  sole clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 S_DATA_RE_IN / S_DATA_IM_IN  in  DATA_W each  IFFT output sample.
REQ-008 S_DATA_INDEX_IN  in  LOG2N  time index of sample within symbol (any order).
REQ-009 S_DATA_VALID  in  1; S_DATA_LAST  in  1  IFFT end-of-symbol marker.
REQ-010 S_DATA_READY  out  1  input accepted on VALID&READY.
REQ-011 M_DATA_RE_OUT / M_DATA_IM_OUT  out  DATA_W each  framed time sample.
REQ-012 M_DATA_VALID  out  1; M_DATA_READY  in  1; M_DATA_FIRST  out  1 first beat of CP; M_DATA_LAST  out  1 last beat of symbol.
REQ-013 EVENT_LAST_MISMATCH  out  1  one-cycle pulse on S_DATA_LAST inconsistent with index.

Function
REQ-014 Two symbol banks (ping-pong), each N x 2*DATA_W; accepted beat written at address S_DATA_INDEX_IN of current write bank.
REQ-015 Per-bank write count; bank commits (marked full) on the edge accepting its N-th beat; write pointer then toggles to other bank.
REQ-016 S_DATA_READY = 1 iff current write bank not full; deasserts same cycle both banks full.
REQ-017 EVENT_LAST_MISMATCH pulses cycle after an accepted beat where S_DATA_LAST=1 and count!=N-1, or S_DATA_LAST=0 and count==N-1; commit is count-based, unaffected by the pulse.
REQ-018 Read FSM states IDLE, CP, BODY; IDLE->CP when read bank full (or IDLE->BODY if CP_LEN=0).
REQ-019 CP emits addresses N-CP_LEN..N-1; BODY emits 0..N-1; total CP_LEN+N beats per symbol.
REQ-020 End of BODY: read bank freed, read pointer toggles; next state CP if other bank full (no gap beat), else IDLE.
REQ-021 Synchronous-read RAM plus one output register; first M_DATA_VALID at 2nd rising edge after commit edge when read FSM IDLE.
REQ-022 While M_DATA_VALID & !M_DATA_READY all M_DATA_* held stable; address advances only on handshake; full throughput one beat/cycle with READY=1.
REQ-023 M_DATA_FIRST on first CP beat (first BODY beat if CP_LEN=0); M_DATA_LAST on BODY address N-1; both only with VALID.
REQ-024 Output data bit-exact copy of stored sample, no scaling/rounding; REAL_ONLY=1 -> IM output 0.
REQ-025 Simultaneous commit of one bank and free of other in same cycle: both take effect; no beat lost or duplicated.
REQ-026 Sample data not reset; bank contents after reset are don't-care and never emitted before rewritten.

Reset
REQ-027 RST high: banks empty, pointers to bank 0, write counts 0, FSM IDLE, M_DATA_VALID/FIRST/LAST/EVENT_LAST_MISMATCH 0, M_DATA_RE/IM_OUT 0, S_DATA_READY 0 during RST, 1 first cycle after.
REQ-028 RST mid-symbol (either side) discards partial and committed symbols; no output beat after RST until a full new symbol commits.

Verification
REQ-029 One symbol, sample k=k, indices 0..127 in order, LAST on 127, READY=1 -> 160 beats: 96..127 then 0..127, FIRST on beat 0, LAST on beat 159, no mismatch.
REQ-030 Bit-reversed index order input -> identical output sequence to REQ-029.
REQ-031 Three back-to-back symbols, M_DATA_READY=0 throughout -> S_DATA_READY drops after 256th accepted beat; release READY -> 480 contiguous valid beats, correct per-symbol data.
REQ-032 Random M_DATA_READY toggling -> outputs stable while stalled, no drop/duplicate vs. reference model.
REQ-033 LAST asserted on beat 100 and not on 127 -> two EVENT_LAST_MISMATCH pulses, symbol still emitted normally.
REQ-034 RST asserted at output beat 50 with second bank full -> all outputs 0 next cycle, nothing emitted until new symbol; CP_LEN=0, REAL_ONLY=1 build -> 128 beats, FIRST on index 0, IM=0.
